rggen_axi4lite_host_adapter: RTL and testbench

// - AXI4-Lite slave front end of the register block. Converts one bus transaction at a time into a

---
 rtl/rggen_axi4lite_pkg.sv | 27 ++
 rtl/rggen_axi4lite_hold_register.sv | 39 +++
 rtl/rggen_axi4lite_host_adapter.sv | 186 ++++++++++++++++++
 tb/tb_rggen_axi4lite_host_adapter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite host adapter: response codes, FSM states
// and the byte-strobe to bit-mask expansion helper.
package rggen_axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_AW = 3'd1,
    ST_WAIT_W  = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_WRESP   = 3'd4,
    ST_RRESP   = 3'd5
  } state_e;

  // Expands up to eight byte strobes into a bit mask; callers truncate to their width.
  function automatic logic [63:0] strobe_to_mask(input logic [7:0] wstrb);
    logic [63:0] mask;
    mask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      mask[8*i+:8] = {8{wstrb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rggen_axi4lite_hold_register.sv
// One-entry capture register for a valid/ready channel: takes a beat on its own
// handshake and holds it until the consumer clears it.
module rggen_axi4lite_hold_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             full_r;
  logic [WIDTH-1:0] data_r;

  assign o_ready = i_enable & ~full_r;
  assign o_full  = full_r;
  assign o_data  = data_r;

  // Capture on handshake, release when the consumer takes the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r <= 1'b0;
      data_r <= '0;
    end else if (i_valid && o_ready) begin
      full_r <= 1'b1;
      data_r <= i_data;
    end else if (i_clear) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

endmodule

// File: rtl/rggen_axi4lite_host_adapter.sv
// AXI4-Lite slave front end: turns one AXI transaction at a time into a single
// access on the broadcast register bus, with SLVERR when nobody acknowledges.
module rggen_axi4lite_host_adapter #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_awvalid,
  output logic                      o_awready,
  input  logic [ADDRESS_WIDTH-1:0]  i_awaddr,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
  output logic                      o_bvalid,
  input  logic                      i_bready,
  output logic [1:0]                o_bresp,
  input  logic                      i_arvalid,
  output logic                      o_arready,
  input  logic [ADDRESS_WIDTH-1:0]  i_araddr,
  output logic                      o_rvalid,
  input  logic                      i_rready,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic [1:0]                o_rresp,
  output logic                      o_register_valid,
  output logic                      o_register_write,
  output logic [ADDRESS_WIDTH-1:0]  o_register_address,
  output logic [DATA_WIDTH-1:0]     o_register_write_data,
  output logic [DATA_WIDTH-1:0]     o_register_strobe,
  input  logic                      i_register_ready,
  input  logic [1:0]                i_register_status,
  input  logic [DATA_WIDTH-1:0]     i_register_read_data
);
  import rggen_axi4lite_pkg::*;

  localparam int LSB = $clog2(DATA_WIDTH / 8);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int WW  = DATA_WIDTH + SW;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  state_e                        state_r;
  logic                          active_r;
  logic                          prio_write_r;
  logic [TW-1:0]                 timer_r;
  logic                          reg_valid_r;
  logic                          reg_write_r;
  logic [ADDRESS_WIDTH-1:0]      reg_address_r;
  logic [DATA_WIDTH-1:0]         reg_wdata_r;
  logic [DATA_WIDTH-1:0]         reg_strobe_r;
  logic                          bvalid_r;
  logic [1:0]                    bresp_r;
  logic                          rvalid_r;
  logic [1:0]                    rresp_r;
  logic [DATA_WIDTH-1:0]         rdata_r;

  logic                          aw_full_s, w_full_s, ar_full_s;
  logic [ADDRESS_WIDTH-LSB-1:0]  aw_addr_s, ar_addr_s;
  logic [WW-1:0]                 w_data_s;
  logic [DATA_WIDTH-1:0]         write_mask_s;
  logic                          idle_s, wait_s, write_complete_s;
  logic                          aw_enable_s, w_enable_s, ar_enable_s;
  logic                          start_write_s, start_read_s;
  logic [1:0]                    resp_s;
  logic                          unused_s;

  assign idle_s           = (state_r == ST_IDLE);
  assign wait_s           = (state_r == ST_WAIT_AW) | (state_r == ST_WAIT_W);
  assign write_complete_s = aw_full_s & w_full_s;
  assign aw_enable_s      = active_r & (idle_s | wait_s);
  assign w_enable_s       = active_r & (idle_s | wait_s);
  // A complete write holding priority blocks AR so the read cannot overtake it.
  assign ar_enable_s      = active_r & idle_s & ~(write_complete_s & prio_write_r);
  assign start_write_s    = write_complete_s & (wait_s | (idle_s & (prio_write_r | ~ar_full_s)));
  assign start_read_s     = idle_s & ar_full_s & ~(write_complete_s & prio_write_r);
  assign write_mask_s     = DATA_WIDTH'(strobe_to_mask(8'(w_data_s[WW-1:DATA_WIDTH])));
  assign resp_s           = (i_register_ready && !i_register_status[1]) ? RESP_OKAY : RESP_SLVERR;
  assign unused_s         = &{1'b0, i_register_status[0], i_awaddr[LSB-1:0], i_araddr[LSB-1:0]};

  rggen_axi4lite_hold_register #(.WIDTH(ADDRESS_WIDTH - LSB)) u_aw_hold (
    .clk(clk), .rst(rst), .i_enable(aw_enable_s), .i_valid(i_awvalid), .o_ready(o_awready),
    .i_data(i_awaddr[ADDRESS_WIDTH-1:LSB]), .i_clear(start_write_s),
    .o_full(aw_full_s), .o_data(aw_addr_s)
  );

  rggen_axi4lite_hold_register #(.WIDTH(WW)) u_w_hold (
    .clk(clk), .rst(rst), .i_enable(w_enable_s), .i_valid(i_wvalid), .o_ready(o_wready),
    .i_data({i_wstrb, i_wdata}), .i_clear(start_write_s),
    .o_full(w_full_s), .o_data(w_data_s)
  );

  rggen_axi4lite_hold_register #(.WIDTH(ADDRESS_WIDTH - LSB)) u_ar_hold (
    .clk(clk), .rst(rst), .i_enable(ar_enable_s), .i_valid(i_arvalid), .o_ready(o_arready),
    .i_data(i_araddr[ADDRESS_WIDTH-1:LSB]), .i_clear(start_read_s),
    .o_full(ar_full_s), .o_data(ar_addr_s)
  );

  // Access sequencing, round-robin arbitration and every registered bus/response output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      active_r      <= 1'b0;
      prio_write_r  <= 1'b1;
      timer_r       <= '0;
      reg_valid_r   <= 1'b0;
      reg_write_r   <= 1'b0;
      reg_address_r <= '0;
      reg_wdata_r   <= '0;
      reg_strobe_r  <= '0;
      bvalid_r      <= 1'b0;
      bresp_r       <= RESP_OKAY;
      rvalid_r      <= 1'b0;
      rresp_r       <= RESP_OKAY;
      rdata_r       <= '0;
    end else begin
      active_r <= 1'b1;
      case (state_r)
        ST_IDLE, ST_WAIT_AW, ST_WAIT_W: begin
          if (start_write_s || start_read_s) begin
            state_r       <= ST_ACCESS;
            timer_r       <= '0;
            prio_write_r  <= start_read_s;
            reg_valid_r   <= 1'b1;
            reg_write_r   <= start_write_s;
            reg_address_r <= {(start_write_s ? aw_addr_s : ar_addr_s), {LSB{1'b0}}};
            reg_wdata_r   <= start_write_s ? w_data_s[DATA_WIDTH-1:0] : '0;
            reg_strobe_r  <= start_write_s ? write_mask_s : '1;
          end else if (idle_s && aw_full_s) begin
            state_r <= ST_WAIT_W;
          end else if (idle_s && w_full_s) begin
            state_r <= ST_WAIT_AW;
          end else begin
            state_r <= state_r;
          end
        end
        ST_ACCESS: begin
          if (i_register_ready || (timer_r == TW'(TIMEOUT_CYCLES - 1))) begin
            reg_valid_r <= 1'b0;
            if (reg_write_r) begin
              state_r  <= ST_WRESP;
              bvalid_r <= 1'b1;
              bresp_r  <= resp_s;
            end else begin
              state_r  <= ST_RRESP;
              rvalid_r <= 1'b1;
              rresp_r  <= resp_s;
              rdata_r  <= i_register_ready ? i_register_read_data : '0;
            end
          end else begin
            timer_r <= timer_r + TW'(1'b1);
          end
        end
        ST_WRESP: begin
          if (i_bready) begin
            bvalid_r <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            bvalid_r <= 1'b1;
          end
        end
        ST_RRESP: begin
          if (i_rready) begin
            rvalid_r <= 1'b0;
            state_r  <= ST_IDLE;
          end else begin
            rvalid_r <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign o_bvalid              = bvalid_r;
  assign o_bresp               = bresp_r;
  assign o_rvalid              = rvalid_r;
  assign o_rresp               = rresp_r;
  assign o_rdata               = rdata_r;
  assign o_register_valid      = reg_valid_r;
  assign o_register_write      = reg_write_r;
  assign o_register_address    = reg_address_r;
  assign o_register_write_data = reg_wdata_r;
  assign o_register_strobe     = reg_strobe_r;

endmodule

// File: tb/tb_rggen_axi4lite_host_adapter.sv
// Scoreboard bench for rggen_axi4lite_host_adapter: stimulus queues expected register
// accesses and responses; negedge monitors pop and compare what the DUT presents.
module tb_rggen_axi4lite_host_adapter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_awvalid = 1'b0, i_wvalid = 1'b0, i_arvalid = 1'b0, i_bready = 1'b1, i_rready = 1'b1;
  logic [AW-1:0] i_awaddr = '0, i_araddr = '0;
  logic [DW-1:0] i_wdata = '0;
  logic [3:0] i_wstrb = '0;
  logic o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
  logic [1:0] o_bresp, o_rresp;
  logic [DW-1:0] o_rdata;
  logic o_register_valid, o_register_write;
  logic [AW-1:0] o_register_address;
  logic [DW-1:0] o_register_write_data, o_register_strobe;
  logic i_register_ready = 1'b0;
  logic [1:0] i_register_status = 2'b00;
  logic [DW-1:0] i_register_read_data = '0;

  rggen_axi4lite_host_adapter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_register_valid(o_register_valid), .o_register_write(o_register_write),
    .o_register_address(o_register_address), .o_register_write_data(o_register_write_data),
    .o_register_strobe(o_register_strobe), .i_register_ready(i_register_ready),
    .i_register_status(i_register_status), .i_register_read_data(i_register_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] strobe;
  } acc_t;

  acc_t          acc_q[$];
  logic [1:0]    b_q[$];
  logic [33:0]   r_q[$];
  int            errors = 0;
  int            checks = 0;

  int            rsp_wait = 1;
  logic [1:0]    rsp_status = 2'b00;
  logic [DW-1:0] rsp_rdata = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register-side responder: acknowledges after rsp_wait cycles of valid; negative never acknowledges.
  initial begin : reg_model
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || i_register_ready || !o_register_valid) begin
        i_register_ready = 1'b0; i_register_status = 2'b00; i_register_read_data = '0; cnt = 0;
      end else if (rsp_wait >= 0 && cnt >= rsp_wait) begin
        i_register_ready = 1'b1; i_register_status = rsp_status; i_register_read_data = rsp_rdata;
      end else begin
        cnt++;
      end
    end
  end

  // Monitors: compare register accesses and responses against the scoreboard queues.
  always @(negedge clk) begin : monitor
    acc_t e;
    if (!rst) begin
      if (o_register_valid && i_register_ready) begin
        chk("acc_expected", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          e = acc_q.pop_front();
          chk("acc_write", o_register_write, e.write);
          chk("acc_addr", o_register_address, e.addr);
          chk("acc_strobe", o_register_strobe, e.strobe);
          if (e.write) chk("acc_wdata", o_register_write_data, e.data);
        end
      end
      if (o_bvalid) begin
        chk("b_expected", b_q.size() > 0, 1);
        if (b_q.size() > 0) begin
          chk("bresp", o_bresp, b_q[0]);
          if (i_bready) void'(b_q.pop_front());
        end
      end
      if (o_rvalid) begin
        chk("r_expected", r_q.size() > 0, 1);
        if (r_q.size() > 0) begin
          chk("rresp", o_rresp, r_q[0][33:32]);
          chk("rdata", o_rdata, r_q[0][31:0]);
          if (i_rready) void'(r_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input bit do_aw, input bit do_w, input bit do_ar, input logic [AW-1:0] awaddr,
                       input logic [DW-1:0] wdata, input logic [3:0] wstrb, input logic [AW-1:0] araddr,
                       output int hs_cyc);
    bit aw_hs, w_hs, ar_hs;
    int n;
    n = 0; hs_cyc = 0;
    @(posedge clk); #1;
    i_awvalid = do_aw; i_awaddr = awaddr; i_wvalid = do_w; i_wdata = wdata; i_wstrb = wstrb;
    i_arvalid = do_ar; i_araddr = araddr;
    while ((i_awvalid || i_wvalid || i_arvalid) && n < 100) begin
      @(negedge clk);
      aw_hs = i_awvalid && o_awready; w_hs = i_wvalid && o_wready; ar_hs = i_arvalid && o_arready;
      @(posedge clk); #1;
      n++;
      if (aw_hs) i_awvalid = 1'b0;
      if (w_hs) i_wvalid = 1'b0;
      if (ar_hs) i_arvalid = 1'b0;
      if (aw_hs || w_hs || ar_hs) hs_cyc = cyc;
    end
    chk("handshake_in_time", n < 100, 1);
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
  endtask

  task automatic wait_resp(input bit is_write, output int c);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (is_write ? o_bvalid : o_rvalid) break;
      n++;
    end
    c = cyc;
    chk("resp_in_time", n < 200, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((acc_q.size() + b_q.size() + r_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("queues_drained", (acc_q.size() + b_q.size() + r_q.size()) == 0, 1);
  endtask

  function automatic logic [127:0] out_vec();
    return {o_awready, o_wready, o_bvalid, o_bresp, o_arready, o_rvalid, o_rdata, o_rresp,
            o_register_valid, o_register_write, o_register_address, o_register_write_data,
            o_register_strobe};
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int hs, c, vcnt, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Write, AW and W together, register acknowledges the cycle after valid.
    acc_q.push_back('{1'b1, 16'h0010, 32'h1234_5678, 32'hFFFF_FFFF});
    b_q.push_back(2'b00);
    issue(1'b1, 1'b1, 1'b0, 16'h0010, 32'h1234_5678, 4'hF, 16'h0000, hs);
    wait_resp(1'b1, c);
    chk("write_latency", c - hs, 3);
    drain();

    // W five cycles ahead of an unaligned AW.
    acc_q.push_back('{1'b1, 16'h0044, 32'hA5A5_5A5A, 32'h0000_FFFF});
    b_q.push_back(2'b00);
    issue(1'b0, 1'b1, 1'b0, 16'h0000, 32'hA5A5_5A5A, 4'b0011, 16'h0000, hs);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wready_low_waiting_aw", o_wready, 0);
    end
    chk("awready_waiting_aw", o_awready, 1);
    chk("arready_blocked_wait", o_arready, 0);
    issue(1'b1, 1'b0, 1'b0, 16'h0046, 32'h0, 4'h0, 16'h0000, hs);
    wait_resp(1'b1, c);
    chk("late_aw_latency", c - hs, 3);
    drain();

    // Read with four wait cycles and three cycles of rready back-pressure.
    rsp_wait = 4; rsp_rdata = 32'hCAFE_F00D; i_rready = 1'b0;
    acc_q.push_back('{1'b0, 16'h0020, 32'h0, 32'hFFFF_FFFF});
    r_q.push_back({2'b00, 32'hCAFE_F00D});
    issue(1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 16'h0020, hs);
    wait_resp(1'b0, c);
    chk("read_wait_latency", c - hs, 6);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 i_rready = 1'b1;
    drain();

    // Unmapped read: no acknowledge, timeout after sixteen cycles of valid.
    rsp_wait = -1;
    r_q.push_back({2'b10, 32'h0});
    issue(1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 4'h0, 16'h0FFC, hs);
    vcnt = 0; n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (o_rvalid) break;
      if (o_register_valid) vcnt++;
      n++;
    end
    chk("timeout_valid_cycles", vcnt, 16);
    chk("timeout_valid_dropped", o_register_valid, 0);
    drain();

    // Two rounds of simultaneous write+read with write priority: W, R, W, R.
    rsp_wait = 1;
    for (int r = 0; r < 2; r++) begin
      rsp_rdata = (r == 0) ? 32'h1111_2222 : 32'h3333_4444;
      acc_q.push_back('{1'b1, (r == 0) ? 16'h0030 : 16'h0038, 32'hDEAD_BEEF,
                        (r == 0) ? 32'h00FF_00FF : 32'hFFFF_0000});
      acc_q.push_back('{1'b0, (r == 0) ? 16'h0034 : 16'h003C, 32'h0, 32'hFFFF_FFFF});
      b_q.push_back(2'b00);
      r_q.push_back({2'b00, rsp_rdata});
      issue(1'b1, 1'b1, 1'b1, (r == 0) ? 16'h0030 : 16'h0038, 32'hDEAD_BEEF,
            (r == 0) ? 4'b0101 : 4'b1100, (r == 0) ? 16'h0034 : 16'h003C, hs);
      drain();
    end

    // Write acknowledged with error status leaves priority with the read.
    rsp_status = 2'b10;
    acc_q.push_back('{1'b1, 16'h0100, 32'h0BAD_0BAD, 32'hFF00_0000});
    b_q.push_back(2'b10);
    issue(1'b1, 1'b1, 1'b0, 16'h0100, 32'h0BAD_0BAD, 4'b1000, 16'h0, hs);
    drain();
    rsp_status = 2'b00;

    // Simultaneous pair now served read first.
    rsp_rdata = 32'h5555_6666;
    acc_q.push_back('{1'b0, 16'h0050, 32'h0, 32'hFFFF_FFFF});
    acc_q.push_back('{1'b1, 16'h0054, 32'h7777_8888, 32'hFFFF_FFFF});
    r_q.push_back({2'b00, 32'h5555_6666});
    b_q.push_back(2'b00);
    issue(1'b1, 1'b1, 1'b1, 16'h0054, 32'h7777_8888, 4'hF, 16'h0050, hs);
    drain();

    // Reset while a write access is on the register bus.
    rsp_wait = -1;
    issue(1'b1, 1'b1, 1'b0, 16'h0060, 32'h0102_0304, 4'hF, 16'h0, hs);
    n = 0;
    while (!o_register_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_before_reset", o_register_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", out_vec(), 128'd0);
    repeat (20) @(negedge clk);
    chk("no_resp_after_reset", {o_bvalid, o_rvalid, o_register_valid}, 3'b000);
    rsp_wait = 1;
    acc_q.push_back('{1'b1, 16'h0068, 32'h0A0B_0C0D, 32'hFFFF_FFFF});
    b_q.push_back(2'b00);
    issue(1'b1, 1'b1, 1'b0, 16'h0068, 32'h0A0B_0C0D, 4'hF, 16'h0, hs);
    wait_resp(1'b1, c);
    chk("post_reset_latency", c - hs, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
